// File: rtl/rcv_fifo_pkg.sv
// Shared sizing, entry type and pointer helper for the receive FIFO.
// Entries are WORDS_PER_ENTRY bus words packed MSB-first.
package rcv_fifo_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_ENTRY = 4;
  localparam int DEPTH           = 3;
  localparam int ENTRY_W         = WORD_W * WORDS_PER_ENTRY;
  localparam int CNT_W           = $clog2(DEPTH + 1);
  localparam int PTR_W           = $clog2(DEPTH);
  localparam int WCNT_W          = $clog2(WORDS_PER_ENTRY);

  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [PTR_W-1:0]   ptr_t;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/rcv_fifo_mem.sv
// Circular buffer of DEPTH complete entries; head visible combinationally, zero when empty.
// Pop on an empty buffer is ignored; push while full is dropped unless a pop frees the slot.
module rcv_fifo_mem
  import rcv_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_dat,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_dat,
  output logic [CNT_W-1:0]   count
);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q] = push_dat;
      tail_d        = ptr_inc(tail_q);
    end
    if (do_pop) begin
      head_d = ptr_inc(head_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_dat = (count_q == '0) ? '0 : mem_q[head_q];
  assign count    = count_q;

endmodule

// File: rtl/rcv_fifo.sv
// Assembles bus words MSB-first into entries and queues them; head entry is combinational.
// Words offered while full are dropped; fix_error discards the partial entry and beats a same-cycle word.
module rcv_fifo
  import rcv_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic [WORD_W-1:0]  HWDATA,
  input  logic               rcv_enq_word,
  input  logic               rcv_deq,
  input  logic               fix_error,
  output logic [ENTRY_W-1:0] rcv_fifo_out,
  output logic               full,
  output logic               empty,
  output logic               framing_error
);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_ENTRY - 1);

  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  entry_t            asm_q, asm_d, asm_ins;
  logic              accept, push;
  logic [CNT_W-1:0]  count;

  always_comb begin
    accept  = rcv_enq_word && !full && !fix_error;
    asm_ins = asm_q;
    asm_ins[ENTRY_W - 1 - WORD_W * int'(word_cnt_q) -: WORD_W] = HWDATA;
    // The completing word goes straight into the store, not via asm_q.
    push       = accept && (word_cnt_q == LAST_WORD);
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    if (fix_error || push) begin
      word_cnt_d = '0;
      asm_d      = '0;
    end else if (accept) begin
      word_cnt_d = word_cnt_q + 1'b1;
      asm_d      = asm_ins;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
    end
  end

  rcv_fifo_mem u_mem (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push),
    .push_dat (asm_ins),
    .pop      (rcv_deq),
    .head_dat (rcv_fifo_out),
    .count    (count)
  );

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0) && (word_cnt_q == '0);
  assign framing_error = (word_cnt_q != '0);

endmodule

// File: tb/tb_rcv_fifo.sv
// Randomized and directed bench for rcv_fifo against a queue-based reference model.
module tb_rcv_fifo;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [31:0]  HWDATA;
  logic         rcv_enq_word, rcv_deq, fix_error;
  logic [127:0] rcv_fifo_out;
  logic         full, empty, framing_error;

  int checks = 0;
  int errors = 0;

  logic [127:0] q_m[$];
  logic [31:0]  part_m[$];

  always #5 clk = ~clk;

  rcv_fifo dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .HWDATA        (HWDATA),
    .rcv_enq_word  (rcv_enq_word),
    .rcv_deq       (rcv_deq),
    .fix_error     (fix_error),
    .rcv_fifo_out  (rcv_fifo_out),
    .full          (full),
    .empty         (empty),
    .framing_error (framing_error)
  );

  function automatic logic [127:0] exp_out();
    return (q_m.size() > 0) ? q_m[0] : 128'h0;
  endfunction

  // Drive one cycle of inputs and advance the reference model at the clock edge.
  task automatic step(input logic enq, input logic [31:0] d, input logic deq, input logic fix);
    logic was_full;
    @(negedge clk);
    rcv_enq_word = enq;
    HWDATA       = d;
    rcv_deq      = deq;
    fix_error    = fix;
    @(posedge clk);
    was_full = (q_m.size() == 3);
    if (deq && q_m.size() > 0) void'(q_m.pop_front());
    if (fix) part_m.delete();
    else if (enq && !was_full) begin
      part_m.push_back(d);
      if (part_m.size() == 4) begin
        q_m.push_back({part_m[0], part_m[1], part_m[2], part_m[3]});
        part_m.delete();
      end
    end
    #1;
    rcv_enq_word = 1'b0;
    rcv_deq      = 1'b0;
    fix_error    = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; rcv_enq_word = 1'b0; rcv_deq = 1'b0; fix_error = 1'b0; HWDATA = '0;
    q_m.delete(); part_m.delete();
    #12;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", framing_error); end
    checks++; if (rcv_fifo_out !== 128'h0) begin errors++; $display("FAIL reset_out got %h exp 0", rcv_fifo_out); end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_single_entry();
    step(1'b1, 32'hAA, 1'b0, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL one_word_empty got %b exp 0", empty); end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL one_word_ferr got %b exp 1", framing_error); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL one_word_full got %b exp 0", full); end
    step(1'b1, 32'hBB, 1'b0, 1'b0);
    step(1'b1, 32'hCC, 1'b0, 1'b0);
    step(1'b1, 32'hDD, 1'b0, 1'b0);
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL entry_ferr got %b exp 0", framing_error); end
    checks++; if (rcv_fifo_out !== 128'h000000AA_000000BB_000000CC_000000DD)
      begin errors++; $display("FAIL entry_out got %h exp %h", rcv_fifo_out, 128'h000000AA_000000BB_000000CC_000000DD); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL entry_deq_empty got %b exp 1", empty); end
    checks++; if (rcv_fifo_out !== 128'h0) begin errors++; $display("FAIL entry_deq_out got %h exp 0", rcv_fifo_out); end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 12; i++) step(1'b1, 32'(i * 'h11), 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (rcv_fifo_out !== 128'h00000011_00000022_00000033_00000044)
      begin errors++; $display("FAIL fill_out got %h exp %h", rcv_fifo_out, 128'h00000011_00000022_00000033_00000044); end
    step(1'b1, 32'hDD, 1'b0, 1'b0);
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL over_ferr got %b exp 0", framing_error); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL over_full got %b exp 1", full); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (rcv_fifo_out !== exp_out())
        begin errors++; $display("FAIL drain_out[%0d] got %h exp %h", i, rcv_fifo_out, exp_out()); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got %b exp 0", full); end
  endtask

  task automatic test_fix_error();
    step(1'b1, 32'h1234, 1'b0, 1'b0);
    step(1'b1, 32'h5678, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL fix_ferr got %b exp 0", framing_error); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fix_empty got %b exp 1", empty); end
    step(1'b1, 32'h9999, 1'b0, 1'b1);
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL fix_prio_ferr got %b exp 0", framing_error); end
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0);
    step(1'b1, 32'hC3, 1'b0, 1'b0);
    step(1'b1, 32'hD4, 1'b0, 1'b0);
    checks++; if (rcv_fifo_out !== 128'h000000A1_000000B2_000000C3_000000D4)
      begin errors++; $display("FAIL fix_next_out got %h exp %h", rcv_fifo_out, 128'h000000A1_000000B2_000000C3_000000D4); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic enq, deq, fix;
    for (int i = 0; i < 500; i++) begin
      enq = ($urandom_range(0, 99) < 65);
      deq = ($urandom_range(0, 99) < 25);
      fix = ($urandom_range(0, 99) < 4);
      step(enq, $urandom(), deq, fix);
      checks++; if (rcv_fifo_out !== exp_out())
        begin errors++; $display("FAIL rand_out[%0d] got %h exp %h", i, rcv_fifo_out, exp_out()); end
      checks++; if ({full, empty, framing_error} !==
                    {q_m.size() == 3, q_m.size() == 0 && part_m.size() == 0, part_m.size() != 0})
        begin errors++; $display("FAIL rand_flags[%0d] got f%b e%b fe%b exp f%b e%b fe%b", i, full, empty,
          framing_error, q_m.size() == 3, q_m.size() == 0 && part_m.size() == 0, part_m.size() != 0); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
    @(negedge clk);
    rcv_deq = 1'b1;
    rcv_enq_word = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    q_m.delete(); part_m.delete();
    checks++; if ({full, empty, framing_error} !== 3'b010)
      begin errors++; $display("FAIL midrst_flags got %b%b%b exp 010", full, empty, framing_error); end
    checks++; if (rcv_fifo_out !== 128'h0) begin errors++; $display("FAIL midrst_out got %h exp 0", rcv_fifo_out); end
    @(posedge clk); #1;
    checks++; if ({full, empty, framing_error} !== 3'b010)
      begin errors++; $display("FAIL midrst_hold got %b%b%b exp 010", full, empty, framing_error); end
    rcv_deq = 1'b0; rcv_enq_word = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0);
    checks++; if (rcv_fifo_out !== 128'h000000F0_000000F1_000000F2_000000F3)
      begin errors++; $display("FAIL postrst_out got %h exp %h", rcv_fifo_out, 128'h000000F0_000000F1_000000F2_000000F3); end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_fill_full();
    test_fix_error();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
